// File: rtl/fft_twiddle_pipe.sv
// fft_twiddle_pipe: 4-stage streaming twiddle multiplier, W*x and -W*x.
// Define FFT_TWIDDLE_QUARTER_ROM_EN to fold a quarter-wave ROM in S1.
module fft_twiddle_pipe #(
  parameter int LOG2N = 6,
  parameter int DATA_W = 16,
  parameter int TW_W = 17,
  parameter int ADD_BIT = 0,
  localparam int KW = (LOG2N > 1) ? LOG2N - 1 : 1,
  localparam int OW = DATA_W + ADD_BIT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DATA_W-1:0] in_i,
  input  logic [DATA_W-1:0] in_q,
  input  logic [KW-1:0] in_k,
  input  logic          in_inv,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [OW-1:0] out_wx_i,
  output logic [OW-1:0] out_wx_q,
  output logic [OW-1:0] out_nwx_i,
  output logic [OW-1:0] out_nwx_q,
  output logic          out_sat
);

  localparam int NH = 1 << (LOG2N - 1);
  localparam int NQ = NH / 2;
  localparam int PW = DATA_W + TW_W;
  localparam int SH = TW_W - 2 - ADD_BIT;
  localparam int SW = PW + 2;
  localparam int RW = SW - SH;
  localparam int RND = 1 << (TW_W - 3);
  localparam real PI = 3.14159265358979323846;
  localparam real SCALE = 2.0 ** (TW_W - 2);
  localparam logic signed [OW-1:0] OMAX = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] OMIN = {1'b1, {(OW-1){1'b0}}};

`ifdef FFT_TWIDDLE_QUARTER_ROM_EN
  localparam bit QROM = (LOG2N > 2);
`else
  localparam bit QROM = 1'b0;
`endif
  localparam int ROM_N = QROM ? NQ + 1 : NH;

  function automatic real taylor(real x, bit is_sin);
    real t;
    real acc;
    t = is_sin ? x : 1.0;
    acc = t;
    for (int n = 1; n < 24; n++) begin
      if (is_sin) t = -t * x * x / real'((2*n) * (2*n+1));
      else t = -t * x * x / real'((2*n-1) * (2*n));
      acc = acc + t;
    end
    return acc;
  endfunction

  function automatic int q_round(real r);
    return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
  endfunction

  // Angles past pi/2 are folded so both ROM builds share identical words
  function automatic int rom_val(int k, bit is_sin);
    int kk;
    int v;
    kk = (2*k > NH) ? NH - k : k;
    v = q_round(SCALE * taylor(2.0 * PI * real'(kk) / real'(2*NH), is_sin));
    return (!is_sin && 2*k > NH) ? -v : v;
  endfunction

  logic signed [TW_W-1:0] cos_rom [ROM_N];
  logic signed [TW_W-1:0] sin_rom [ROM_N];

  for (genvar g = 0; g < ROM_N; g++) begin : g_rom
    localparam int CV = rom_val(g, 1'b0);
    localparam int SV = rom_val(g, 1'b1);
    assign cos_rom[g] = TW_W'(CV);
    assign sin_rom[g] = TW_W'(SV);
  end

  function automatic logic signed [PW-1:0] tw_mul(
    logic signed [DATA_W-1:0] x,
    logic signed [TW_W-1:0] w
  );
    logic signed [PW-1:0] xs;
    xs = PW'(x) <<< (TW_W - 2);
    if (LOG2N > 2) return PW'(x) * PW'(w);
    if (w == '0) return '0;
    return w[TW_W-1] ? -xs : xs;
  endfunction

  function automatic logic [OW:0] sat_fn(logic signed [RW-1:0] v);
    if (v > RW'(OMAX)) return {1'b1, OMAX};
    if (v < RW'(OMIN)) return {1'b1, OMIN};
    return {1'b0, v[OW-1:0]};
  endfunction

  logic advance;
  logic rom_neg;
  logic [KW-1:0] rom_idx;
  logic signed [TW_W-1:0] c_sel, s_dir;
  logic s1_v, s2_v, s3_v, s4_v;
  logic signed [DATA_W-1:0] s1_a, s1_b;
  logic signed [TW_W-1:0] s1_c, s1_s;
  logic signed [PW-1:0] s2_ac, s2_bs, s2_as, s2_bc;
  logic signed [SW-1:0] re_sum, im_sum;
  logic signed [RW-1:0] re_sh, im_sh, s3_re, s3_im;
  logic signed [OW-1:0] wi, wq, ni, nq;
  logic wi_s, wq_s;

  assign advance = !s4_v || out_ready;
  assign in_ready = advance;
  assign out_valid = s4_v;

  assign rom_neg = QROM && (in_k > KW'(NQ));
  assign rom_idx = rom_neg ? KW'(NH - int'(in_k)) : in_k;
  assign c_sel = rom_neg ? -cos_rom[rom_idx] : cos_rom[rom_idx];
  assign s_dir = in_inv ? sin_rom[rom_idx] : -sin_rom[rom_idx];

  assign re_sum = SW'(s2_ac) - SW'(s2_bs) + SW'(RND);
  assign im_sum = SW'(s2_as) + SW'(s2_bc) + SW'(RND);
  assign re_sh = RW'(re_sum >>> SH);
  assign im_sh = RW'(im_sum >>> SH);

  assign {wi_s, wi} = sat_fn(s3_re);
  assign {wq_s, wq} = sat_fn(s3_im);
  assign ni = (wi == OMIN) ? OMAX : -wi;
  assign nq = (wq == OMIN) ? OMAX : -wq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s3_v <= 1'b0;
      s4_v <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s1_c <= '0;
      s1_s <= '0;
      s2_ac <= '0;
      s2_bs <= '0;
      s2_as <= '0;
      s2_bc <= '0;
      s3_re <= '0;
      s3_im <= '0;
      out_wx_i <= '0;
      out_wx_q <= '0;
      out_nwx_i <= '0;
      out_nwx_q <= '0;
      out_sat <= 1'b0;
    end else if (advance) begin
      s1_v <= in_valid;
      s1_a <= in_i;
      s1_b <= in_q;
      s1_c <= c_sel;
      s1_s <= s_dir;
      s2_v <= s1_v;
      s2_ac <= tw_mul(s1_a, s1_c);
      s2_bs <= tw_mul(s1_b, s1_s);
      s2_as <= tw_mul(s1_a, s1_s);
      s2_bc <= tw_mul(s1_b, s1_c);
      s3_v <= s2_v;
      s3_re <= re_sh;
      s3_im <= im_sh;
      s4_v <= s3_v;
      out_wx_i <= wi;
      out_wx_q <= wq;
      out_nwx_i <= ni;
      out_nwx_q <= nq;
      out_sat <= wi_s | wq_s | (wi == OMIN) | (wq == OMIN);
    end
  end

endmodule

// File: doc/fft_twiddle_pipe.md
# fft_twiddle_pipe

Fully pipelined, back-pressurable twiddle-factor multiplier for the radix-2 FFT butterfly stages. It replaces the per-sample `en`/`outValid` multiplier with a streaming block that accepts one sample per clock. The block is generalised in FFT size, data width and twiddle width, and selects forward/inverse direction at run time. It produces W·x and −W·x for the butterfly adders, with rounding and saturation, and sits between the stage delay-line buffer and the butterfly add/sub logic.

## Interface
- `LOG2N`, 6: log2 of the FFT size N; legal range 1..10.
- `DATA_W`, 16: input I/Q width, two's complement.
- `TW_W`, 17: twiddle word width; 1.0 = 2^(TW_W−2).
- `ADD_BIT`, 0: 1 adds one guard bit to the outputs.
- `clk` in 1: clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `in_valid` in 1: input sample valid.
- `in_ready` out 1: block can accept; a transfer occurs when `in_valid & in_ready`.
- `in_i`, `in_q` in DATA_W: input sample x.
- `in_k` in max(LOG2N−1,1): twiddle index k, 0..N/2−1.
- `in_inv` in 1: 0 = forward, W = exp(−j2πk/N); 1 = inverse, W = exp(+j2πk/N). Sampled per sample.
- `out_valid` out 1: output valid.
- `out_ready` in 1: downstream accepts.
- `out_wx_i`, `out_wx_q` out DATA_W+ADD_BIT: W·x.
- `out_nwx_i`, `out_nwx_q` out DATA_W+ADD_BIT: −W·x.
- `out_sat` out 1: this sample saturated in any of the four outputs.

## Operation
- Pipeline has four register stages:
  - S1: fold k, read ROM (c, s), register x and `in_inv`.
  - S2: four signed products a·c, b·s, a·s, b·c.
  - S3: re = a·c − b·s and im = a·s + b·c, where s = −sin for forward and +sin for inverse. Add the rounding constant 2^(TW_W−3), then arithmetic shift right by TW_W−2−ADD_BIT.
  - S4: saturate to DATA_W+ADD_BIT, form the negation (saturated, so −min becomes max), set `out_sat`.
- ROM holds cos/sin in Q(TW_W−2), computed at elaboration from constant functions; no external .mem files.
- LOG2N=1: W=1; multiplication is bypassed but latency is unchanged.
- LOG2N=2: k=1 is an exact ±j swap with negation; no multipliers, latency unchanged.
- All sample fields (x, k, inv) travel together; per-sample direction changes need no flush.

## Timing
- Latency is 4 cycles from the accepting edge to `out_valid` high with that result, at every LOG2N.
- Throughput is one sample per clock when `out_ready` is high.
- Global stall: advance = !out_valid | out_ready. `in_ready` = advance, combinational from `out_ready`.
- While stalled, every stage register holds, and outputs stay stable until accepted.
- Bubbles are not collapsed; invalid stages still advance only on advance.
- Reset values: `out_valid`=0, all data outputs=0, `out_sat`=0, all stage valid bits=0, `in_ready`=1.
- Reset asserted mid-stream discards all in-flight samples. The first valid output after release comes 4 accepted cycles after the first post-reset input.
- Simultaneous input accept and output accept on the same edge is legal and loses nothing.

## Configuration
- `FFT_TWIDDLE_QUARTER_ROM_EN` defined: ROM stores N/4+1 entries for k = 0..N/4.
  - For k > N/4: c = −cos[N/2−k] and sin = sin[N/2−k], mapped in S1.
  - Outputs are bit-identical to the full table.
- Macro undefined: full N/2-entry table indexed directly by k.
- For LOG2N ≤ 2 the macro has no effect.

## Test plan
Test 1 is run at LOG2N=6, DATA_W=16, TW_W=17, ADD_BIT=0 unless noted; tests 2–6 use the same configuration.
1. Identity: k=0, x=(1000,−2000), forward → wx=(1000,−2000), nwx=(−1000,2000), `out_sat`=0, exactly 4 cycles after accept.
2. Quarter turn: k=16, x=(1000,0).
   - forward → wx=(0,−1000).
   - in_inv=1 on the next cycle → wx=(0,1000).
   - Back-to-back outputs appear in order.
3. Rounding and saturation.
   - k=8, x=(32767,0), forward → wx=(23169,−23169).
   - x=(−32768,−32768), k=8 → wx=(−32768,0), nwx=(32767,0), `out_sat`=1.
4. Backpressure: stream k=0..31 continuously and hold `out_ready`=0 for 3 cycles mid-stream.
   - `in_ready` drops in the same cycle.
   - Outputs stay stable.
   - All 32 results arrive in order, with none lost or duplicated.
5. Reset mid-operation: assert `reset` with 3 samples in flight.
   - `out_valid`=0 immediately, and none of the in-flight samples emerge.
   - A new sample after release emerges after 4 cycles.
6. Build with and without `FFT_TWIDDLE_QUARTER_ROM_EN` and sweep all k in both directions against a real-arithmetic model; the two builds must produce bit-identical outputs.
